dv_status_monitor: RTL
======================

Name: dv_status_monitor

Overview:
- Synthesizable monitor for the status-word protocol that firmware drives on a user-IO status bus (for example mprj_io[31:16]).
- Decodes start, pass and fail codes for a parametrised number of test phases, then reports overall pass, fail or timeout.
- Sits in DV benches and in the optional on-chip self-test wrapper, replacing per-test hard-coded checkbit decoding.

Parameters:
- ID_W, 8: width of the phase-id field (low bits of the status word).
- TAG_W, 8: width of the tag field (high bits). STATUS_W = TAG_W + ID_W.
- START_TAG, 8'hA0: tag that marks a phase start.
- RESULT_TAG, 8'hAB: tag that marks a phase result; id bit0 = 1 means pass, 0 means fail.
- NUM_PHASES, 3: number of passing phases required for overall pass (1..2^(ID_W-1)).
- STABLE_CYCLES, 2: consecutive identical samples required before a code is accepted (>=1).
- TIMEOUT_CYCLES, 300000: cycles allowed without an accepted code; 0 disables the timeout.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous return to IDLE; zeroes counters and flags.
- status_in  in  STATUS_W  raw status bus; asynchronous to clock.
- busy  out  1  a phase is started and awaiting its result.
- phase_id  out  ID_W  id of the current or last started phase (bit0 = 0).
- pass_count  out  clog2(NUM_PHASES+1)  number of phases passed.
- done  out  1  terminal state reached.
- pass  out  1  all phases passed.
- fail  out  1  a phase failed or a protocol error occurred.
- timeout  out  1  timeout expired.
- proto_err  out  1  fail caused by a protocol violation.
- fail_code  out  STATUS_W  accepted code that caused fail.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, synchronizer and filter cleared to 0.
- Input path: 2-flop synchronizer, then stability filter. A code is accepted (one-cycle accept strobe) when the synchronized value has been identical for STABLE_CYCLES cycles and differs from the last accepted code. Latency from a bus change to accept is 2+STABLE_CYCLES cycles. Glitches shorter than that are never accepted.
- Decode: tag = code[STATUS_W-1:ID_W], id = code[ID_W-1:0].
  - Start: tag == START_TAG and id[0] == 0.
  - Result: tag == RESULT_TAG; phase = {id[ID_W-1:1], 1'b0}.
  - Any other code is ignored (it still restarts the timeout).
- FSM states: IDLE, RUN, PASS, FAIL, TIMEOUT.
  - IDLE + start: latch phase_id, go to RUN, busy=1.
  - IDLE + result: proto_err=1, FAIL.
  - RUN + result, phase == phase_id, pass bit set: pass_count+1. Go to PASS if the new count == NUM_PHASES, otherwise IDLE.
  - RUN + result, phase == phase_id, pass bit clear: FAIL.
  - RUN + result with mismatched phase, or RUN + start: proto_err=1, FAIL.
- FAIL, PASS and TIMEOUT are sticky until reset or clear. done = PASS | FAIL | TIMEOUT. busy = RUN.
- fail_code latches the accepted code on entry to FAIL.
- Timeout counter: counts in IDLE/RUN, restarts to 0 on accept. On reaching TIMEOUT_CYCLES-1, the state becomes TIMEOUT and timeout=1. The counter saturates in terminal states.
- Simultaneous events:
  - clear beats everything.
  - An accept in the same cycle as timeout expiry wins (the code is processed, the counter restarts).
  - Accepts arriving in terminal states are ignored.
- Reset mid-phase: immediate return to IDLE, all state lost.

Optional Feature:
- Macro DV_STATUS_MON_EVENT_LOG_EN.
- When defined: adds a 4-entry FIFO of accepted codes.
  - Ports: log_valid out 1, log_data out STATUS_W, log_pop in 1, log_ovf out 1.
  - Push on every accept; pop when log_pop & log_valid.
  - Full + push drops the new code and sets sticky log_ovf.
  - Simultaneous push and pop while full: both performed, no overflow.
  - clear or reset empties the FIFO and clears log_ovf.
- When undefined: the ports still exist, outputs are tied to 0, log_pop is ignored, and no FIFO storage is built.

Decomposition:
- Package dv_status_mon_pkg holds:
  - FSM state enum.
  - Default tag constants (START_TAG, RESULT_TAG).
  - Function to extract phase from id.
- Sub-module dv_status_sync_filter: synchronizer, stability filter and change detect. Outputs accept strobe plus code.

Test Plan:
- NUM_PHASES=3. Drive A040, AB41, A020, AB21, A010, AB11, each held 10 cycles -> pass=1, done=1, pass_count=3, fail=0.
- A020 then AB20 -> fail=1, proto_err=0, fail_code=16'hAB20, state sticky. Subsequent AB21 ignored.
- A040 then AB21 -> fail=1, proto_err=1, fail_code=16'hAB21. Separately, AB41 while in IDLE -> proto_err=1.
- STABLE_CYCLES=2. 1-cycle glitch to A040 -> no accept. Held 2 cycles -> busy=1 exactly 4 cycles after the bus change.
- TIMEOUT_CYCLES=100. A040 then silence -> timeout=1 on cycle 100 after accept. A code accepted on the expiry cycle -> no timeout.
- With DV_STATUS_MON_EVENT_LOG_EN: 5 codes and no pops -> log_ovf=1, first 4 codes popped in order, 5th lost. Assert clear -> log_valid=0, log_ovf=0.

Source files
------------

// File: rtl/dv_status_mon_pkg.sv
// rtl/dv_status_mon_pkg.sv - shared types, default tags and phase helper for dv_status_monitor
package dv_status_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } mon_state_e;

    localparam logic [7:0] DEF_START_TAG  = 8'hA0;
    localparam logic [7:0] DEF_RESULT_TAG = 8'hAB;

    // Result ids carry the pass bit in bit0; the phase is the id with that bit cleared.
    function automatic logic [31:0] phase_of(input logic [31:0] id);
        return {id[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/dv_status_sync_filter.sv
// rtl/dv_status_sync_filter.sv - status bus synchronizer, stability filter and change detect
module dv_status_sync_filter
    import dv_status_mon_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] status_in,
    output logic             accept,
    output logic [WIDTH-1:0] code
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] last_code;
    logic [CW-1:0]    stable_cnt;

    // stable_cnt counts how many cycles sync2 has held its current value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            last_code  <= '0;
            stable_cnt <= '0;
        end else begin
            sync1 <= status_in;
            sync2 <= sync1;
            if (sync1 != sync2) begin
                stable_cnt <= CW'(1);
            end else if (stable_cnt != CW'(STABLE_CYCLES)) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
            if (accept) begin
                last_code <= sync2;
            end
        end
    end

    assign accept = (stable_cnt == CW'(STABLE_CYCLES)) && (sync2 != last_code);
    assign code   = sync2;

endmodule

// File: rtl/dv_status_monitor.sv
// rtl/dv_status_monitor.sv - status-word protocol monitor; optional event log via DV_STATUS_MON_EVENT_LOG_EN
module dv_status_monitor
    import dv_status_mon_pkg::*;
#(
    parameter int               ID_W           = 8,
    parameter int               TAG_W          = 8,
    parameter logic [TAG_W-1:0] START_TAG      = TAG_W'(DEF_START_TAG),
    parameter logic [TAG_W-1:0] RESULT_TAG     = TAG_W'(DEF_RESULT_TAG),
    parameter int               NUM_PHASES     = 3,
    parameter int               STABLE_CYCLES  = 2,
    parameter int               TIMEOUT_CYCLES = 300000,
    localparam int              STATUS_W       = TAG_W + ID_W,
    localparam int              PC_W           = $clog2(NUM_PHASES + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic [STATUS_W-1:0] status_in,
    output logic                busy,
    output logic [ID_W-1:0]     phase_id,
    output logic [PC_W-1:0]     pass_count,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic                timeout,
    output logic                proto_err,
    output logic [STATUS_W-1:0] fail_code,
    output logic                log_valid,
    output logic [STATUS_W-1:0] log_data,
    input  logic                log_pop,
    output logic                log_ovf
);

    localparam int T_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int T_W   = (T_MAX > 0) ? $clog2(T_MAX + 1) : 1;

    logic                accept;
    logic [STATUS_W-1:0] code;
    logic [TAG_W-1:0]    tag;
    logic [ID_W-1:0]     id;
    logic [ID_W-1:0]     phase;
    logic                is_start;
    logic                is_result;
    logic                expiry;
    logic [PC_W-1:0]     pc_next;
    logic [T_W-1:0]      tmo_cnt;
    mon_state_e          state;

    dv_status_sync_filter #(
        .WIDTH         (STATUS_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clock     (clock),
        .reset     (reset),
        .status_in (status_in),
        .accept    (accept),
        .code      (code)
    );

    assign tag       = code[STATUS_W-1:ID_W];
    assign id        = code[ID_W-1:0];
    assign phase     = ID_W'(phase_of(32'(id)));
    assign is_start  = (tag == START_TAG) && !id[0];
    assign is_result = (tag == RESULT_TAG);
    assign expiry    = (TIMEOUT_CYCLES != 0) && (tmo_cnt == T_W'(T_MAX));
    assign pc_next   = pass_count + 1'b1;

    // An accept on the expiry cycle is processed instead of timing out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            phase_id   <= '0;
            pass_count <= '0;
            proto_err  <= 1'b0;
            fail_code  <= '0;
            tmo_cnt    <= '0;
        end else if (clear) begin
            state      <= ST_IDLE;
            phase_id   <= '0;
            pass_count <= '0;
            proto_err  <= 1'b0;
            fail_code  <= '0;
            tmo_cnt    <= '0;
        end else if (state == ST_IDLE || state == ST_RUN) begin
            if (accept) begin
                tmo_cnt <= '0;
                if (state == ST_IDLE) begin
                    if (is_start) begin
                        phase_id <= id;
                        state    <= ST_RUN;
                    end else if (is_result) begin
                        proto_err <= 1'b1;
                        fail_code <= code;
                        state     <= ST_FAIL;
                    end
                end else if (is_start || (is_result && phase != phase_id)) begin
                    proto_err <= 1'b1;
                    fail_code <= code;
                    state     <= ST_FAIL;
                end else if (is_result) begin
                    if (id[0]) begin
                        pass_count <= pc_next;
                        state      <= (pc_next == PC_W'(NUM_PHASES)) ? ST_PASS : ST_IDLE;
                    end else begin
                        fail_code <= code;
                        state     <= ST_FAIL;
                    end
                end
            end else if (expiry) begin
                state <= ST_TIMEOUT;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign busy    = (state == ST_RUN);
    assign pass    = (state == ST_PASS);
    assign fail    = (state == ST_FAIL);
    assign timeout = (state == ST_TIMEOUT);
    assign done    = pass | fail | timeout;

`ifdef DV_STATUS_MON_EVENT_LOG_EN
    logic [STATUS_W-1:0] log_mem [4];
    logic [1:0]          wr_ptr;
    logic [1:0]          rd_ptr;
    logic [2:0]          log_cnt;
    logic                log_full;
    logic                do_push;
    logic                do_pop;

    assign log_full  = (log_cnt == 3'd4);
    assign do_pop    = log_pop && (log_cnt != 3'd0);
    assign do_push   = accept && (!log_full || do_pop);
    assign log_valid = (log_cnt != 3'd0);
    assign log_data  = log_mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            log_mem[wr_ptr] <= code;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            log_cnt <= '0;
            log_ovf <= 1'b0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            log_cnt <= '0;
            log_ovf <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            log_cnt <= log_cnt + 3'(do_push) - 3'(do_pop);
            if (accept && !do_push) begin
                log_ovf <= 1'b1;
            end
        end
    end
`else
    logic unused_log_pop;
    assign unused_log_pop = log_pop;
    assign log_valid      = 1'b0;
    assign log_data       = '0;
    assign log_ovf        = 1'b0;
`endif

endmodule
